// File: rtl/lcd_bus_ctrl.sv
// HD44780-style LCD write controller: power-up wait, init sequence,
// then round-robin arbitration between two write ports.
module lcd_bus_ctrl #(
  parameter int T_PWRUP = 750000,
  parameter int T_SETUP = 2,
  parameter int T_EH    = 12,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 2000,
  parameter int T_CLEAR = 82000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       RS,
  output logic       E,
  output logic [7:0] D,
  output logic       busy,
  output logic       init_done
);

  localparam int M1   = (T_PWRUP > T_CLEAR) ? T_PWRUP : T_CLEAR;
  localparam int M2   = (T_EXEC > T_EH) ? T_EXEC : T_EH;
  localparam int M3   = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int M4   = (M1 > M2) ? M1 : M2;
  localparam int MAXT = (M4 > M3) ? M4 : M3;
  localparam int W    = $clog2(MAXT + 1);

  typedef enum logic [2:0] {
    PWRUP, INIT, IDLE, SETUP, EHIGH, HOLD, EXEC
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   cnt, cnt_n;
  logic [1:0]     idx, idx_n;
  logic           last, last_n;
  logic           gnt, tick;
  logic           rs_n, e_n, ack0_n, ack1_n;
  logic           busy_n, done_n;
  logic [7:0]     d_n;

  // Counter holds cycles remaining in the current state, so a
  // state loaded with N lasts exactly N cycles.
  function automatic logic [W-1:0] load(
    input state_t s, input logic rs, input logic [7:0] d
  );
    case (s)
      PWRUP: load = W'(T_PWRUP);
      SETUP: load = W'(T_SETUP);
      EHIGH: load = W'(T_EH);
      HOLD:  load = W'(T_HOLD);
      EXEC:  load = (!rs && (d inside {8'h01, 8'h02, 8'h03}))
                    ? W'(T_CLEAR) : W'(T_EXEC);
      default: load = '0;
    endcase
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  assign tick = (cnt <= W'(1));
  assign gnt  = (req0 && req1) ? ~last : req1;

  always_comb begin
    state_n = state;
    cnt_n   = (cnt != '0) ? cnt - W'(1) : cnt;
    idx_n   = idx;
    last_n  = last;
    rs_n    = RS;
    d_n     = D;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    done_n  = init_done;
    case (state)
      PWRUP: if (tick) state_n = INIT;
      INIT: begin
        state_n = SETUP;
        rs_n    = 1'b0;
        d_n     = init_byte(idx);
      end
      IDLE: if (init_done && (req0 || req1)) begin
        state_n = SETUP;
        last_n  = gnt;
        rs_n    = gnt ? rs1 : rs0;
        d_n     = gnt ? data1 : data0;
        ack1_n  = gnt;
        ack0_n  = ~gnt;
      end
      SETUP: if (tick) state_n = EHIGH;
      EHIGH: if (tick) state_n = HOLD;
      HOLD:  if (tick) state_n = EXEC;
      EXEC: if (tick) begin
        if (init_done) begin
          state_n = IDLE;
        end else if (idx == 2'd3) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          idx_n   = idx + 2'd1;
          state_n = INIT;
        end
      end
      default: state_n = PWRUP;
    endcase
    if (state_n != state) cnt_n = load(state_n, rs_n, d_n);
    e_n    = (state_n == EHIGH);
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state     <= PWRUP;
      cnt       <= W'(T_PWRUP);
      idx       <= 2'd0;
      last      <= 1'b1;
      RS        <= 1'b0;
      E         <= 1'b0;
      D         <= 8'h00;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b1;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      last      <= last_n;
      RS        <= rs_n;
      E         <= e_n;
      D         <= d_n;
      ack0      <= ack0_n;
      ack1      <= ack1_n;
      busy      <= busy_n;
      init_done <= done_n;
    end
  end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Directed bench for lcd_bus_ctrl: init sequence, single writes,
// round-robin ties, clear timing, early requests and mid-write reset.
module tb_lcd_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0, rs0, ack0, req1, rs1, ack1;
  logic [7:0] data0, data1;
  logic       RS, E, busy, init_done;
  logic [7:0] D;

  lcd_bus_ctrl #(
    .T_PWRUP(10), .T_SETUP(2), .T_EH(3),
    .T_HOLD(2), .T_EXEC(20), .T_CLEAR(50)
  ) dut (
    .CLOCK_50(clk), .RESET(rst),
    .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
    .RS(RS), .E(E), .D(D), .busy(busy), .init_done(init_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic       tr_e[0:199], tr_rs[0:199], tr_busy[0:199];
  logic       tr_done[0:199], tr_ack0[0:199], tr_ack1[0:199];
  logic [7:0] tr_d[0:199];
  logic [7:0] init_seq[0:3] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  // Index i holds values seen in the i-th cycle after the start point.
  task automatic capture(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      @(negedge clk);
      tr_e[i]    = E;
      tr_rs[i]   = RS;
      tr_d[i]    = D;
      tr_busy[i] = busy;
      tr_done[i] = init_done;
      tr_ack0[i] = ack0;
      tr_ack1[i] = ack1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++;
    if ({E, RS, D, ack0, ack1, busy, init_done} !== 13'b0_0_00000000_0_0_1_0) begin
      n_bad++;
      $display("FAIL reset_outputs got E=%b RS=%b D=%h a0=%b a1=%b busy=%b done=%b want 0 0 00 0 0 1 0",
               E, RS, D, ack0, ack1, busy, init_done);
    end
  endtask

  task automatic test_init();
    int err, rises, b, derr, rerr;
    logic [4:0] pat;
    logic prev;
    @(negedge clk);
    rst = 1'b0;
    capture(1, 160);
    err = 0;
    for (int i = 1; i <= 12; i++)
      if (tr_e[i] !== 1'b0 || tr_busy[i] !== 1'b1) err++;
    n_cmp++;
    if (err != 0) begin
      n_bad++;
      $display("FAIL init_pwrup_quiet got %0d bad cycles want 0", err);
    end
    for (int k = 0; k < 4; k++) begin
      b = 28 * k;
      pat = {tr_e[12+b], tr_e[13+b], tr_e[14+b], tr_e[15+b], tr_e[16+b]};
      n_cmp++;
      if (pat !== 5'b01110) begin
        n_bad++;
        $display("FAIL init_pulse%0d got E=%b want 01110", k, pat);
      end
      derr = 0;
      rerr = 0;
      for (int i = 11; i <= 17; i++) begin
        if (tr_d[i+b] !== init_seq[k]) derr++;
        if (tr_rs[i+b] !== 1'b0) rerr++;
      end
      n_cmp++;
      if (derr != 0 || rerr != 0) begin
        n_bad++;
        $display("FAIL init_data%0d got D=%h (%0d bad, rs bad %0d) want %h",
                 k, tr_d[14+b], derr, rerr, init_seq[k]);
      end
    end
    rises = 0;
    prev = 1'b0;
    for (int i = 1; i <= 152; i++) begin
      if (tr_e[i] === 1'b1 && prev !== 1'b1) rises++;
      prev = tr_e[i];
    end
    n_cmp++;
    if (rises != 4) begin
      n_bad++;
      $display("FAIL init_pulse_count got %0d want 4", rises);
    end
    n_cmp++;
    if ({tr_busy[151], tr_done[151], tr_busy[152], tr_done[152]} !== 4'b1001) begin
      n_bad++;
      $display("FAIL init_end got busy/done@151=%b%b @152=%b%b want 10 01",
               tr_busy[151], tr_done[151], tr_busy[152], tr_done[152]);
    end
  endtask

  task automatic test_single();
    rs1 = 1'b1;
    data1 = 8'h41;
    req1 = 1'b1;
    capture(1, 2);
    req1 = 1'b0;
    capture(3, 28);
    n_cmp++;
    if ({tr_ack1[1], tr_ack0[1], tr_rs[1], tr_e[1]} !== 4'b1010 || tr_d[1] !== 8'h41) begin
      n_bad++;
      $display("FAIL single_grant got ack1=%b ack0=%b RS=%b E=%b D=%h want 1 0 1 0 41",
               tr_ack1[1], tr_ack0[1], tr_rs[1], tr_e[1], tr_d[1]);
    end
    n_cmp++;
    if ({tr_ack1[2], tr_e[2]} !== 2'b00) begin
      n_bad++;
      $display("FAIL single_ack_width got ack1=%b E=%b want 0 0", tr_ack1[2], tr_e[2]);
    end
    n_cmp++;
    if ({tr_e[3], tr_e[4], tr_e[5], tr_e[6]} !== 4'b1110) begin
      n_bad++;
      $display("FAIL single_e got %b%b%b%b want 1110", tr_e[3], tr_e[4], tr_e[5], tr_e[6]);
    end
    n_cmp++;
    if ({tr_busy[27], tr_busy[28]} !== 2'b10) begin
      n_bad++;
      $display("FAIL single_exec got busy@27/28=%b%b want 10", tr_busy[27], tr_busy[28]);
    end
  endtask

  task automatic test_rr();
    int got, overlap;
    int want[3] = '{0, 1, 0};
    bit ok;
    overlap = 0;
    rs0 = 1'b1;
    data0 = 8'hA0;
    rs1 = 1'b1;
    data1 = 8'hB1;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int t = 0; t < 3; t++) begin
      got = -1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (ack0 === 1'b1 && ack1 === 1'b1) overlap++;
        if (ack0 === 1'b1) got = 0;
        else if (ack1 === 1'b1) got = 1;
        if (got >= 0) break;
      end
      n_cmp++;
      if (got != want[t] || D !== (got == 1 ? 8'hB1 : 8'hA0)) begin
        n_bad++;
        $display("FAIL rr_grant%0d got port %0d D=%h want port %0d", t, got, D, want[t]);
      end
      if (t == 2) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      @(negedge clk);
      n_cmp++;
      if ({ack0, ack1} !== 2'b00) begin
        n_bad++;
        $display("FAIL rr_ack_width%0d got %b%b want 00", t, ack0, ack1);
      end
    end
    wait_idle(ok);
    n_cmp++;
    if (ok !== 1'b1 || overlap != 0) begin
      n_bad++;
      $display("FAIL rr_overlap got idle=%b overlap=%0d want 1 0", ok, overlap);
    end
  endtask

  task automatic test_clear();
    rs0 = 1'b0;
    data0 = 8'h02;
    req0 = 1'b1;
    capture(1, 1);
    req0 = 1'b0;
    capture(2, 58);
    n_cmp++;
    if ({tr_ack0[1], tr_rs[1]} !== 2'b10 || tr_d[1] !== 8'h02) begin
      n_bad++;
      $display("FAIL clear_grant got ack0=%b RS=%b D=%h want 1 0 02", tr_ack0[1], tr_rs[1], tr_d[1]);
    end
    n_cmp++;
    if ({tr_busy[57], tr_busy[58]} !== 2'b10) begin
      n_bad++;
      $display("FAIL clear_exec got busy@57/58=%b%b want 10", tr_busy[57], tr_busy[58]);
    end
    n_cmp++;
    if (tr_d[58] !== 8'h02 || tr_e[58] !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_hold_d got D=%h E=%b want 02 0", tr_d[58], tr_e[58]);
    end
    data0 = 8'h80;
    req0 = 1'b1;
    capture(1, 1);
    req0 = 1'b0;
    capture(2, 28);
    n_cmp++;
    if (tr_ack0[1] !== 1'b1 || {tr_busy[27], tr_busy[28]} !== 2'b10) begin
      n_bad++;
      $display("FAIL normal_exec got ack0=%b busy@27/28=%b%b want 1 10",
               tr_ack0[1], tr_busy[27], tr_busy[28]);
    end
  endtask

  task automatic test_reset_mid();
    rs1 = 1'b1;
    data1 = 8'h77;
    req1 = 1'b1;
    capture(1, 4);
    req1 = 1'b0;
    n_cmp++;
    if (tr_e[4] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_in_ehigh got E=%b want 1", tr_e[4]);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({E, ack0, ack1, busy, init_done, RS} !== 6'b000100 || D !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_reset got E=%b a0=%b a1=%b busy=%b done=%b RS=%b D=%h want 0 0 0 1 0 0 00",
               E, ack0, ack1, busy, init_done, RS, D);
    end
    rs0 = 1'b1;
    data0 = 8'h55;
    req0 = 1'b1;
    @(negedge clk);
    test_init();
  endtask

  task automatic test_early_req();
    int early;
    bit ok;
    early = 0;
    for (int i = 1; i <= 152; i++)
      if (tr_ack0[i] !== 1'b0 || tr_ack1[i] !== 1'b0) early++;
    n_cmp++;
    if (early != 0) begin
      n_bad++;
      $display("FAIL early_no_ack got %0d ack cycles want 0", early);
    end
    n_cmp++;
    if (tr_ack0[153] !== 1'b1 || tr_d[153] !== 8'h55 || tr_ack0[154] !== 1'b0) begin
      n_bad++;
      $display("FAIL early_first_idle got ack0@153=%b D=%h ack0@154=%b want 1 55 0",
               tr_ack0[153], tr_d[153], tr_ack0[154]);
    end
    req0 = 1'b0;
    wait_idle(ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL early_done got idle=%b want 1", ok);
    end
  endtask

  initial begin
    req0 = 1'b0;
    rs0 = 1'b0;
    data0 = 8'h00;
    req1 = 1'b0;
    rs1 = 1'b0;
    data1 = 8'h00;
    test_reset();
    test_init();
    test_single();
    test_rr();
    test_clear();
    test_reset_mid();
    test_early_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_bus_ctrl.md
LCD_BUS_CTRL -- requirements
Module: lcd_bus_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- T_PWRUP, 750000, power-up wait in cycles (15 ms at 50 MHz).
- T_SETUP, 2, cycles RS/D are valid before E rises.
- T_EH, 12, cycles E is held high.
- T_HOLD, 2, cycles RS/D are held after E falls.
- T_EXEC, 2000, post-write wait in cycles for normal writes (40 us).
- T_CLEAR, 82000, post-write wait in cycles for clear/home commands (1.64 ms).

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- CLOCK_50, in, 1, sole clock, rising edge.
- RESET, in, 1, asynchronous active-high reset.
- req0, in, 1, port 0 write request.
- rs0, in, 1, port 0 register select.
- data0, in, 8, port 0 byte.
- ack0, out, 1, port 0 accept pulse.
- req1, in, 1, port 1 write request.
- rs1, in, 1, port 1 register select.
- data1, in, 8, port 1 byte.
- ack1, out, 1, port 1 accept pulse.
- RS, out, 1, LCD register select.
- E, out, 1, LCD enable strobe.
- D, out, 8, LCD data bus.
- busy, out, 1, high when not accepting requests.
- init_done, out, 1, init sequence complete.

REQ-003 All outputs SHALL be registered.

Function
REQ-004 The state machine SHALL have the states PWRUP, INIT, IDLE, SETUP, EHIGH, HOLD and EXEC.
REQ-005 PWRUP SHALL last T_PWRUP cycles and then go to INIT.
REQ-006 INIT SHALL issue four writes with RS=0, in order 0x38, 0x0C, 0x06, 0x01, each through the SETUP, EHIGH, HOLD and EXEC states.
REQ-007 After the fourth init write's EXEC, the block SHALL enter IDLE and set init_done=1, which SHALL stay 1 until reset.
REQ-008 SETUP, EHIGH and HOLD SHALL each last exactly T_SETUP, T_EH and T_HOLD cycles respectively.
REQ-009 E SHALL be 1 only in EHIGH.
REQ-010 RS and D SHALL be constant from SETUP entry through HOLD exit.
REQ-011 EXEC SHALL last T_CLEAR cycles when the latched RS=0 and D is 0x01, 0x02 or 0x03; otherwise it SHALL last T_EXEC cycles.
REQ-012 busy SHALL be 0 only in IDLE.
REQ-013 Requests SHALL be sampled only in IDLE; req0 and req1 SHALL be ignored, with no ack, before init_done.
REQ-014 On grant, the block SHALL latch the granted port's rs/data into RS/D, pulse that port's ack for exactly one cycle (the cycle after the sampling edge), and enter SETUP in that same cycle.
REQ-015 A requester SHALL hold req/rs/data stable until its ack and SHALL deassert req or change data in the cycle after ack; the block SHALL NOT resample before the next IDLE.
REQ-016 Arbitration SHALL be round-robin: when one request is present, that port SHALL be granted; on a tie, the port not granted last SHALL win.
REQ-017 The last-grant register SHALL reset to port 1, so port 0 wins the first tie.
REQ-018 A request present on the first IDLE cycle SHALL be granted immediately, giving a minimum back-to-back period of 1+T_SETUP+T_EH+T_HOLD+T_EXEC cycles.
REQ-019 ack0 and ack1 SHALL never be high in the same cycle.
REQ-020 The shared cycle counter SHALL be ceil(log2(max parameter + 1)) bits wide, SHALL count down to 0 without wrap, and SHALL be reloaded on every state entry.
REQ-021 D after EXEC SHALL keep the last written byte; E SHALL return to 0.

Reset
REQ-022 While RESET=1, asynchronously: E=0, RS=0, D=0x00, ack0=0, ack1=0, busy=1, init_done=0, state=PWRUP, counter=T_PWRUP, last-grant=port 1.
REQ-023 RESET asserted mid-write, including during EHIGH, SHALL drop E immediately and discard the transfer with no ack.
REQ-024 After RESET deasserts, the full PWRUP and INIT sequence SHALL rerun.

Verification
Benches SHALL use T_PWRUP=10, T_SETUP=2, T_EH=3, T_HOLD=2, T_EXEC=20, T_CLEAR=50.
REQ-025 Release reset -> E low and busy=1 for 10 cycles; four E pulses of 3 cycles each with D=0x38, 0x0C, 0x06, 0x01 and RS=0; last gap 50 cycles; then init_done=1 and busy=0.
REQ-026 Hold req1 with rs1=1, data1=0x41 after init -> ack1 one cycle later; E rises 2 cycles after RS=1/D=0x41 appear; E high 3 cycles; busy clears 20+2 cycles after E falls.
REQ-027 Hold req0 and req1 simultaneously for three transfers -> grants in order port 0, port 1, port 0; ack0 and ack1 never overlap.
REQ-028 Port 0 writes rs0=0, data0=0x02 -> EXEC lasts 50 cycles; then port 0 writes data0=0x80 -> EXEC lasts 20 cycles.
REQ-029 Assert req0 during INIT -> no ack0 until init_done=1, then ack0 on the first IDLE cycle.
REQ-030 Pulse RESET during EHIGH -> E=0 in the same cycle, no ack, and the PWRUP/INIT sequence repeats in full.
